// File: rtl/rlt_framer_if.sv
// Valid/ready stream bundle used on both sides of the result framer.
// The master drives data/last/val and the slave answers with rdy.
`timescale 1ns/1ps

interface rlt_framer_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] data;
  logic             last;
  logic             val;
  logic             rdy;

  modport master (output data, output last, output val, input rdy);
  modport slave  (input data, input last, input val, output rdy);
endinterface

// File: rtl/rlt_framer.sv
// Result framer: chops the unbounded cnn result stream into frames made of
// one header word followed by len body words, for the host DMA engine.
// LEN and TAG are shadowed when the header is built, so reprogramming them
// only affects the next frame.
`timescale 1ns/1ps

module rlt_framer #(
  parameter int             CFG_DWIDTH    = 32,
  parameter int             CFG_AWIDTH    = 5,
  parameter int             STR_WIDTH     = 64,
  parameter logic [4:0]     CFG_ADDR_CTRL = 5'd28,
  parameter logic [4:0]     CFG_ADDR_LEN  = 5'd29,
  parameter logic [4:0]     CFG_ADDR_TAG  = 5'd30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CFG_DWIDTH-1:0] cfg_data,
  input  logic [CFG_AWIDTH-1:0] cfg_addr,
  input  logic                  cfg_valid,
  rlt_framer_if.slave           up,
  rlt_framer_if.master          dn,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                 enable;
  logic [15:0]          len;
  logic [31:0]          tag;

  logic [15:0]          len_s;
  logic [15:0]          len_s_nxt;
  logic [31:0]          tag_s;
  logic [31:0]          tag_s_nxt;
  logic [15:0]          seq;
  logic [15:0]          seq_nxt;
  logic [15:0]          frame_cnt_nxt;
  logic [15:0]          body_cnt;
  logic [15:0]          body_cnt_nxt;

  logic [STR_WIDTH-1:0] out_data;
  logic [STR_WIDTH-1:0] out_data_nxt;
  logic                 out_last;
  logic                 out_last_nxt;
  logic                 out_val;
  logic                 out_val_nxt;

  logic                 out_free;
  logic                 dn_take;
  logic                 up_rdy;
  logic                 up_take;
  logic                 body_end;

  // The upstream last flag has no meaning for a raw result stream.
  logic                 unused_up_last;
  assign unused_up_last = up.last;

  // The output register may take a new word when empty or being drained now.
  assign out_free = !out_val || dn.rdy;
  assign dn_take  = out_val && dn.rdy;
  assign up_rdy   = (state == BODY) && out_free;
  assign up_take  = up.val && up_rdy;
  assign body_end = (body_cnt == (len_s - 16'd1));

  assign up.rdy   = up_rdy;
  assign dn.data  = out_data;
  assign dn.last  = out_last;
  assign dn.val   = out_val;

  // Configuration registers written from the shared cfg bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable <= 1'b0;
      len    <= 16'd0;
      tag    <= 32'd0;
    end else if (cfg_valid) begin
      if (cfg_addr == CFG_ADDR_CTRL) enable <= cfg_data[0];
      if (cfg_addr == CFG_ADDR_LEN)  len    <= cfg_data[15:0];
      if (cfg_addr == CFG_ADDR_TAG)  tag    <= cfg_data[31:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic plus the output register, shadow and counter updates.
  always_comb begin
    state_nxt     = state;
    len_s_nxt     = len_s;
    tag_s_nxt     = tag_s;
    seq_nxt       = seq;
    frame_cnt_nxt = frame_cnt;
    body_cnt_nxt  = body_cnt;
    out_data_nxt  = out_data;
    out_last_nxt  = out_last;
    out_val_nxt   = out_val && !dn.rdy;

    case (state)
      IDLE: begin
        if (enable && (len != 16'd0)) begin
          len_s_nxt = len;
          tag_s_nxt = tag;
          if (out_free) begin
            out_data_nxt       = '0;
            out_data_nxt[63:0] = {tag, seq, len};
            out_last_nxt       = 1'b0;
            out_val_nxt        = 1'b1;
            state_nxt          = HEAD;
          end
        end
      end
      HEAD: begin
        if (dn_take) begin
          body_cnt_nxt = 16'd0;
          state_nxt    = BODY;
        end
      end
      BODY: begin
        if (up_take) begin
          out_data_nxt = up.data;
          out_last_nxt = body_end;
          out_val_nxt  = 1'b1;
          body_cnt_nxt = body_cnt + 16'd1;
          if (body_end) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (dn_take) begin
          frame_cnt_nxt = frame_cnt + 16'd1;
          seq_nxt       = seq + 16'd1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: output word, shadows and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_s     <= 16'd0;
      tag_s     <= 32'd0;
      seq       <= 16'd0;
      frame_cnt <= 16'd0;
      body_cnt  <= 16'd0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_val   <= 1'b0;
    end else begin
      len_s     <= len_s_nxt;
      tag_s     <= tag_s_nxt;
      seq       <= seq_nxt;
      frame_cnt <= frame_cnt_nxt;
      body_cnt  <= body_cnt_nxt;
      out_data  <= out_data_nxt;
      out_last  <= out_last_nxt;
      out_val   <= out_val_nxt;
    end
  end

endmodule

// File: tb/tb_rlt_framer.sv
// Directed bench for rlt_framer: basic frame, back-to-back frames,
// random back-pressure, mid-frame reconfiguration, zero length and
// asynchronous reset in the middle of a frame.
`timescale 1ns/1ps

module tb_rlt_framer;

  localparam logic [4:0] A_CTRL = 5'd28;
  localparam logic [4:0] A_LEN  = 5'd29;
  localparam logic [4:0] A_TAG  = 5'd30;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cfg_data = '0;
  logic [4:0]  cfg_addr = '0;
  logic        cfg_valid = 1'b0;
  logic [15:0] frame_cnt;

  rlt_framer_if #(.WIDTH(64)) up_if ();
  rlt_framer_if #(.WIDTH(64)) dn_if ();

  rlt_framer #(
    .CFG_DWIDTH(32),
    .CFG_AWIDTH(5),
    .STR_WIDTH(64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_data  (cfg_data),
    .cfg_addr  (cfg_addr),
    .cfg_valid (cfg_valid),
    .up        (up_if),
    .dn        (dn_if),
    .frame_cnt (frame_cnt)
  );

  int          checks = 0;
  int          fails  = 0;
  int          cycle  = 0;
  logic [63:0] feed_q[$];
  logic [63:0] got_data[$];
  logic        got_last[$];
  int          got_cyc[$];
  logic [63:0] exp_d[$];
  logic        exp_l[$];
  bit          take_up    = 1'b0;
  bit          prev_stall = 1'b0;
  bit          stall_chk  = 1'b0;
  bit          rand_rdy   = 1'b0;
  bit          saw_val    = 1'b0;
  logic        rdy_const  = 1'b1;
  logic [63:0] prev_data  = '0;
  logic        prev_last  = 1'b0;

  always #5 clk = ~clk;

  initial begin
    up_if.val  = 1'b0;
    up_if.data = '0;
    up_if.last = 1'b0;
    dn_if.rdy  = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Feed the upstream queue and drive dn_rdy just after each rising edge.
  always @(posedge clk) begin
    cycle++;
    #1;
    if (take_up && feed_q.size() > 0) void'(feed_q.pop_front());
    take_up    = 1'b0;
    up_if.val  = (feed_q.size() > 0);
    up_if.data = (feed_q.size() > 0) ? feed_q[0] : 64'd0;
    dn_if.rdy  = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_const;
  end

  // Observe handshakes mid-cycle; inputs are stable until the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
      take_up    = 1'b0;
    end else begin
      if (stall_chk && prev_stall) begin
        checkOutput("stall_val",  64'(dn_if.val),  64'd1);
        checkOutput("stall_data", dn_if.data,      prev_data);
        checkOutput("stall_last", 64'(dn_if.last), 64'(prev_last));
      end
      if (stall_chk && dn_if.val && !dn_if.rdy)
        checkOutput("up_rdy_bp", 64'(up_if.rdy), 64'd0);
      if (dn_if.val) saw_val = 1'b1;
      if (dn_if.val && dn_if.rdy) begin
        got_data.push_back(dn_if.data);
        got_last.push_back(dn_if.last);
        got_cyc.push_back(cycle);
      end
      prev_stall = dn_if.val && !dn_if.rdy;
      prev_data  = dn_if.data;
      prev_last  = dn_if.last;
      take_up    = up_if.val && up_if.rdy;
    end
  end

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk);
    #2;
    cfg_addr  = a;
    cfg_data  = d;
    cfg_valid = 1'b1;
    @(posedge clk);
    #2;
    cfg_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [63:0] first, input int n);
    for (int i = 0; i < n; i++) feed_q.push_back(first + 64'(i));
  endtask

  task automatic clear_logs();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    feed_q.delete();
    clear_logs();
    rst = 1'b1;
  endtask

  task automatic wait_dn(input int n, input int budget);
    int k = 0;
    while (got_data.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    checkOutput($sformatf("wait_dn%0d", n), 64'(got_data.size() >= n), 64'd1);
  endtask

  task automatic check_got(input string name);
    checkOutput({name, "_count"}, 64'(got_data.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < got_data.size()) begin
        checkOutput($sformatf("%s_data%0d", name, i), got_data[i], exp_d[i]);
        checkOutput($sformatf("%s_last%0d", name, i), 64'(got_last[i]), 64'(exp_l[i]));
      end
    end
  endtask

  initial begin
    // Reset state
    #12;
    checkOutput("rst_dn_val",    64'(dn_if.val),  64'd0);
    checkOutput("rst_dn_last",   64'(dn_if.last), 64'd0);
    checkOutput("rst_up_rdy",    64'(up_if.rdy),  64'd0);
    checkOutput("rst_dn_data",   dn_if.data,      64'd0);
    checkOutput("rst_frame_cnt", 64'(frame_cnt),  64'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;

    // Basic frame, then enable cleared after the header
    $display("[TB] basic frame");
    rdy_const = 1'b1;
    cfg_write(A_LEN, 32'd4);
    cfg_write(A_TAG, 32'hA5A5_0001);
    applyStimulus(64'd1, 4);
    cfg_write(A_CTRL, 32'd1);
    wait_dn(1, 100);
    cfg_write(A_CTRL, 32'd0);
    wait_dn(5, 100);
    repeat (10) @(posedge clk);
    exp_d = '{64'hA5A5_0001_0000_0004, 64'd1, 64'd2, 64'd3, 64'd4};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    check_got("basic");
    checkOutput("basic_frame_cnt", 64'(frame_cnt), 64'd1);
    checkOutput("disable_up_rdy",  64'(up_if.rdy), 64'd0);
    checkOutput("disable_dn_val",  64'(dn_if.val), 64'd0);

    // Back-to-back frames of two words
    $display("[TB] back-to-back");
    do_reset();
    cfg_write(A_LEN, 32'd2);
    cfg_write(A_TAG, 32'h0000_00B2);
    applyStimulus(64'h11, 6);
    cfg_write(A_CTRL, 32'd1);
    wait_dn(7, 100);
    cfg_write(A_CTRL, 32'd0);
    wait_dn(9, 100);
    repeat (10) @(posedge clk);
    exp_d = '{64'h0000_00B2_0000_0002, 64'h11, 64'h12,
              64'h0000_00B2_0001_0002, 64'h13, 64'h14,
              64'h0000_00B2_0002_0002, 64'h15, 64'h16};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    check_got("b2b");
    checkOutput("b2b_frame_cnt", 64'(frame_cnt), 64'd3);
    if (got_cyc.size() >= 9) begin
      checkOutput("b2b_gap1",   64'((got_cyc[3] - got_cyc[2]) <= 3), 64'd1);
      checkOutput("b2b_gap2",   64'((got_cyc[6] - got_cyc[5]) <= 3), 64'd1);
      checkOutput("b2b_stream", 64'(got_cyc[2] - got_cyc[1]),        64'd1);
    end

    // Random back-pressure with stability checks
    $display("[TB] back-pressure");
    do_reset();
    cfg_write(A_LEN, 32'd3);
    cfg_write(A_TAG, 32'hC3C3_C3C3);
    applyStimulus(64'h21, 6);
    stall_chk = 1'b1;
    rand_rdy  = 1'b1;
    cfg_write(A_CTRL, 32'd1);
    wait_dn(5, 400);
    cfg_write(A_CTRL, 32'd0);
    wait_dn(8, 400);
    rand_rdy  = 1'b0;
    repeat (10) @(posedge clk);
    stall_chk = 1'b0;
    exp_d = '{64'hC3C3_C3C3_0000_0003, 64'h21, 64'h22, 64'h23,
              64'hC3C3_C3C3_0001_0003, 64'h24, 64'h25, 64'h26};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    check_got("bp");
    checkOutput("bp_frame_cnt", 64'(frame_cnt), 64'd2);

    // Zero length while enabled
    $display("[TB] zero length");
    do_reset();
    saw_val = 1'b0;
    cfg_write(A_LEN, 32'd0);
    cfg_write(A_CTRL, 32'd1);
    applyStimulus(64'h55, 1);
    repeat (20) @(posedge clk);
    checkOutput("len0_saw_val", 64'(saw_val),   64'd0);
    checkOutput("len0_up_rdy",  64'(up_if.rdy), 64'd0);
    checkOutput("len0_count",   64'(got_data.size()), 64'd0);

    // Length reprogrammed mid-frame
    $display("[TB] config mid-frame");
    do_reset();
    cfg_write(A_LEN, 32'd4);
    cfg_write(A_TAG, 32'h0000_0044);
    applyStimulus(64'h31, 6);
    cfg_write(A_CTRL, 32'd1);
    wait_dn(3, 100);
    cfg_write(A_LEN, 32'd2);
    wait_dn(6, 100);
    cfg_write(A_CTRL, 32'd0);
    wait_dn(8, 100);
    repeat (10) @(posedge clk);
    exp_d = '{64'h0000_0044_0000_0004, 64'h31, 64'h32, 64'h33, 64'h34,
              64'h0000_0044_0001_0002, 64'h35, 64'h36};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    check_got("midcfg");
    checkOutput("midcfg_frame_cnt", 64'(frame_cnt), 64'd2);

    // Asynchronous reset while a body word is stalled in the output register
    $display("[TB] async reset mid-frame");
    clear_logs();
    cfg_write(A_LEN, 32'd4);
    cfg_write(A_TAG, 32'h0000_0066);
    applyStimulus(64'h41, 4);
    cfg_write(A_CTRL, 32'd1);
    wait_dn(3, 100);
    rdy_const = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("pre_rst_dn_val",    64'(dn_if.val), 64'd1);
    checkOutput("pre_rst_frame_cnt", 64'(frame_cnt), 64'd2);
    rst = 1'b0;
    #1;
    checkOutput("arst_dn_val",    64'(dn_if.val),  64'd0);
    checkOutput("arst_up_rdy",    64'(up_if.rdy),  64'd0);
    checkOutput("arst_frame_cnt", 64'(frame_cnt),  64'd0);
    checkOutput("arst_dn_data",   dn_if.data,      64'd0);
    repeat (2) @(posedge clk);
    #3;
    feed_q.delete();
    clear_logs();
    rst = 1'b1;
    rdy_const = 1'b1;
    cfg_write(A_LEN, 32'd1);
    cfg_write(A_TAG, 32'h0000_0077);
    applyStimulus(64'h99, 1);
    cfg_write(A_CTRL, 32'd1);
    wait_dn(1, 100);
    cfg_write(A_CTRL, 32'd0);
    wait_dn(2, 100);
    repeat (10) @(posedge clk);
    exp_d = '{64'h0000_0077_0000_0001, 64'h99};
    exp_l = '{1'b0, 1'b1};
    check_got("postrst");
    checkOutput("postrst_frame_cnt", 64'(frame_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/rlt_framer.md
Name: rlt_framer

Overview:
- Sits directly downstream of the cnn result stream (str_rlt_bus/val/rdy).
- Cuts the unbounded result word stream into fixed-length frames for the host DMA.
- Each frame is one header word followed by LEN body words; dn_last marks the final body word.
- Configured from the shared cfg_data/cfg_addr/cfg_valid bus used by the cnn block.

Parameters:
- CFG_DWIDTH, 32, config data width
- CFG_AWIDTH, 5, config address width
- STR_WIDTH, 64, stream word width on both sides; must be at least 64
- CFG_ADDR_CTRL, 5'd28, ctrl register address; bit0 is enable
- CFG_ADDR_LEN, 5'd29, body words per frame; bits [15:0] used
- CFG_ADDR_TAG, 5'd30, 32-bit frame tag

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cfg_data  in  CFG_DWIDTH  config write data
- cfg_addr  in  CFG_AWIDTH  config write address
- cfg_valid  in  1  config write strobe, one cycle per write
- up_data  in  STR_WIDTH  result word from cnn str_rlt_bus
- up_val  in  1  result word valid
- up_rdy  out  1  framer accepts result word
- dn_data  out  STR_WIDTH  framed output word
- dn_last  out  1  final body word of frame
- dn_val  out  1  output word valid
- dn_rdy  in  1  downstream accepts
- frame_cnt  out  16  frames completed since reset; wraps at 65535->0

Behaviour:
- Reset (rst=0, async): ctrl, len, tag, frame_cnt and the sequence number clear to 0. dn_val, dn_last, up_rdy are 0 and dn_data is 0. State is IDLE. In-flight words are discarded.
- Config writes:
  - A write takes effect when cfg_valid=1 and cfg_addr matches.
  - Writes to other addresses are ignored.
  - The LEN and TAG registers may change at any time. Writes mid-frame do not affect the current frame, because they are shadowed at header emission.
- Handshake: a transfer occurs on a rising clk when val=1 and rdy=1. dn_data/dn_last/dn_val come from one output register and hold stable while dn_val=1 and dn_rdy=0.
- out_free = !dn_val | dn_rdy. This is combinational; a path from dn_rdy to up_rdy is permitted.
- State machine:
  - IDLE:
    - up_rdy=0.
    - If enable=1 and len!=0, latch len_s=len and tag_s=tag.
    - When out_free, load the header and go to HEAD.
  - HEAD:
    - The header sits in the output register.
    - Header layout: dn_data[63:32]=tag_s, [31:16]=seq, [15:0]=len_s, and bits above 63 are zero.
    - dn_last=0.
    - The header is held until accepted. On acceptance go to BODY with body_cnt=0.
  - BODY:
    - up_rdy = out_free.
    - Each accepted up word loads the output register with dn_val=1, dn_data=up_data, and dn_last=(body_cnt==len_s-1). body_cnt then increments.
    - When the last word is loaded, go to DRAIN.
  - DRAIN:
    - up_rdy=0.
    - When the last word is accepted downstream: frame_cnt+=1 and seq+=1 (both 16-bit wrap), then go to IDLE.
- Throughput: one word per cycle in BODY when dn_rdy is held high. The gap between frames is at most 2 cycles: DRAIN to IDLE, then IDLE loads the header.
- Clearing enable mid-frame: the current frame completes. The framer then stays in IDLE with up_rdy=0.
- len=0 while enabled: no frames are emitted, the framer stays in IDLE and up_rdy=0.
- The framer never drops or duplicates an up word. up_rdy is 0 outside BODY, so results back-pressure into the cnn.
- If up_val and a config write occur in the same cycle, both are handled independently.
- Latency: an up word accepted at edge N appears on dn at edge N (registered output, visible the next cycle).

Test Plan:
- Basic frame: LEN=4, TAG=0xA5A5_0001, enable=1, feed 4 words 1..4, dn_rdy=1.
  - Expect dn = {0xA5A50001,0x0000,0x0004}, then 1, 2, 3, 4.
  - dn_last only on 4; frame_cnt=1.
- Back-to-back frames: LEN=2, feed 6 words continuously.
  - Expect 3 frames with seq 0, 1, 2 in the headers and frame_cnt=3.
  - Each inter-frame gap is at most 2 cycles.
- Back-pressure: LEN=3, random dn_rdy at 50% duty.
  - dn_data/dn_last stay stable while stalled; the output sequence is identical to the unstalled run.
  - up_rdy drops whenever dn_val=1 and dn_rdy=0.
- Config mid-frame: LEN=4, then write LEN=2 after 2 body words.
  - The current frame carries 4 body words; the next header shows len 2.
- Disable / zero length:
  - Clear enable after the header: the frame completes, then up_rdy stays 0.
  - LEN=0 with enable=1: no dn_val ever asserts.
- Async reset mid-frame: assert rst=0 between clock edges during BODY.
  - dn_val, up_rdy and frame_cnt go to 0 immediately.
  - After release and reconfig, the first header has seq=0.
